lines_cleared_counter: RTL

Upstream feeder for the lines-cleared display region. Accumulates the number of lines the player clears per piece lock, saturates at the displayable maximum, and converts the binary total to decimal ASCII characters with a sequential double-dabble engine. The character bus goes straight to the lines-cleared pixel driver's digit renderers. Updates are atomic, so the display never scans a half-converted value.

---
 rtl/lines_cleared_counter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lines_cleared_counter.sv
// lines_cleared_counter
//   Accumulates lines cleared per piece lock, saturating at 10^DIGITS-1, and
//   converts the binary total into ASCII decimal characters with a sequential
//   double-dabble engine. The character bus is only ever rewritten in a single
//   edge, so the renderer never sees a half-converted number.
//
//   Optional build macro: LC_LEADING_BLANK_EN
//     defined   -> leading zero digits (above the LSD) shown as ASCII space
//     undefined -> all digits shown as numerals with leading zeros
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   clear        new-game pulse, zeroes the total and aborts any conversion
//   lc_valid     one-cycle pulse, lc_num is valid
//   lc_num[2:0]  lines cleared by that lock, legal 0..4 (5..7 ignored)
//   count_out    binary running total
//   digit_chars  ASCII digits, most-significant digit in the top byte
//   busy         conversion in progress, digit_chars lags count_out

module lines_cleared_counter #(
    parameter int DIGITS = 3,
    parameter int CNT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  lc_valid,
    input  logic [2:0]            lc_num,
    output logic [CNT_W-1:0]      count_out,
    output logic [8*DIGITS-1:0]   digit_chars,
    output logic                  busy
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SH_W   = BCD_W + CNT_W;
    localparam int ITER_W = $clog2(CNT_W + 1);

    localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(10**DIGITS - 1);
    localparam logic [ITER_W-1:0]   ITER_LAST = ITER_W'(CNT_W);
    localparam logic [ITER_W-1:0]   ITER_ONE  = ITER_W'(1);
`ifdef LC_LEADING_BLANK_EN
    localparam logic [8*DIGITS-1:0] ZERO_CHARS = {{(DIGITS-1){8'h20}}, 8'h30};
`else
    localparam logic [8*DIGITS-1:0] ZERO_CHARS = {DIGITS{8'h30}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // One double-dabble iteration: nibbles >= 5 get +3, then shift left by one.
    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] adj;
        logic [3:0]      nib;
        adj = sh;
        for (int i = 0; i < DIGITS; i++) begin
            nib = adj[CNT_W + 4*i +: 4];
            adj[CNT_W + 4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
        return {adj[SH_W-2:0], 1'b0};
    endfunction

    // BCD digits to ASCII bytes; LSD is always a numeral.
    function automatic logic [8*DIGITS-1:0] bcd_to_chars(input logic [BCD_W-1:0] bcd);
        logic [8*DIGITS-1:0] ch;
        logic [3:0]          nib;
`ifdef LC_LEADING_BLANK_EN
        logic                lead;
        lead = 1'b1;
`endif
        ch = {(8*DIGITS){1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
`ifdef LC_LEADING_BLANK_EN
            if (lead && (nib == 4'd0) && (i > 0)) begin
                ch[8*i +: 8] = 8'h20;
            end else begin
                ch[8*i +: 8] = 8'h30 + {4'h0, nib};
                lead         = 1'b0;
            end
`else
            ch[8*i +: 8] = 8'h30 + {4'h0, nib};
`endif
        end
        return ch;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  dirty_q, dirty_d;
    logic                  busy_q, busy_d;
    logic [SH_W-1:0]       shreg_q, shreg_d;
    logic [ITER_W-1:0]     iter_q, iter_d;
    logic [8*DIGITS-1:0]   chars_q, chars_d;

    logic [CNT_W:0]        sum_s;
    logic [CNT_W-1:0]      sat_s;
    logic                  cnt_change_s;

    // Accumulator next value: widened sum, saturate, illegal lc_num ignored.
    always_comb begin
        count_d      = count_q;
        cnt_change_s = 1'b0;
        sum_s        = {1'b0, count_q} + {{(CNT_W-2){1'b0}}, lc_num};
        sat_s        = (sum_s > {1'b0, MAX_CNT}) ? MAX_CNT : sum_s[CNT_W-1:0];
        if (clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (lc_valid && (lc_num <= 3'd4)) begin
            count_d      = sat_s;
            cnt_change_s = (sat_s != count_q);
        end else begin
            count_d = count_q;
        end
    end

    // Conversion FSM next state, shift register, character latch and flags.
    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        busy_d  = busy_q;
        shreg_d = shreg_q;
        iter_d  = iter_q;
        chars_d = chars_q;
        if (clear) begin
            state_d = ST_IDLE;
            dirty_d = 1'b0;
            busy_d  = 1'b0;
            chars_d = ZERO_CHARS;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dirty_q) begin
                        shreg_d = {{BCD_W{1'b0}}, count_q};
                        iter_d  = {ITER_W{1'b0}};
                        dirty_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // CNT_W shifts, then one terminating cycle when the counter hits CNT_W
                    if (iter_q == ITER_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        shreg_d = dabble_step(shreg_q);
                        iter_d  = iter_q + ITER_ONE;
                    end
                end
                ST_LOAD: begin
                    chars_d = bcd_to_chars(shreg_q[SH_W-1 -: BCD_W]);
                    state_d = ST_IDLE;
                    // a count change seen during (or on) this conversion keeps busy up
                    busy_d  = dirty_q | cnt_change_s;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
            // a change on the snapshot edge must survive the dirty clear above
            if (cnt_change_s) begin
                dirty_d = 1'b1;
            end else begin
                dirty_d = dirty_d;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= {CNT_W{1'b0}};
            dirty_q <= 1'b0;
            busy_q  <= 1'b0;
            shreg_q <= {SH_W{1'b0}};
            iter_q  <= {ITER_W{1'b0}};
            chars_q <= ZERO_CHARS;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dirty_q <= dirty_d;
            busy_q  <= busy_d;
            shreg_q <= shreg_d;
            iter_q  <= iter_d;
            chars_q <= chars_d;
        end
    end

    assign count_out   = count_q;
    assign digit_chars = chars_q;
    assign busy        = busy_q;

endmodule
